net_ncore_ndr_req: RTL and testbench

//  Parametrised request network: NCORES L2 request ports to NDR directory slices.
//  - Successor to the fixed 2-core/2-directory interconnect.
//  - Slice = address-interleave bits of each request.
//  - Per-slice round-robin arbitration; per-slice FIFO; valid/retry handshake on every port.
//  - Tags each forwarded request with its source core id.

---
 rtl/net_ncore_ndr_req.sv | 149 ++++++++++++++
 tb/tb_net_ncore_ndr_req.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/net_ncore_ndr_req.sv
// Request network: NCORES L2 request ports routed by address-interleave bits to NDR directory
// slices, with per-slice round-robin arbitration and a per-slice output FIFO. Optional macro: NET_REQ_BYPASS_EN.
module net_ncore_ndr_req #(
  parameter int NCORES    = 2,
  parameter int NDR       = 2,
  parameter int PAYLOAD_W = 64,
  parameter int ADDR_LSB  = 6,
  parameter int FIFO_D    = 2,
  localparam int SRC_W    = (NCORES > 1) ? $clog2(NCORES) : 1,
  localparam int SL_W     = (NDR > 1) ? $clog2(NDR) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCORES-1:0]        l2todr_valid,
  output logic [NCORES-1:0]        l2todr_retry,
  input  logic [NCORES*PAYLOAD_W-1:0] l2todr_req,
  output logic [NDR-1:0]           drtomem_valid,
  input  logic [NDR-1:0]           drtomem_retry,
  output logic [NDR*PAYLOAD_W-1:0] drtomem_req,
  output logic [NDR*SRC_W-1:0]     drtomem_src
);

  localparam int PTR_W = $clog2(FIFO_D);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = SRC_W + PAYLOAD_W;

  logic [ENT_W-1:0] mem_q    [NDR][FIFO_D];
  logic [ENT_W-1:0] mem_d    [NDR][FIFO_D];
  logic [PTR_W-1:0] wr_ptr_q [NDR];
  logic [PTR_W-1:0] wr_ptr_d [NDR];
  logic [PTR_W-1:0] rd_ptr_q [NDR];
  logic [PTR_W-1:0] rd_ptr_d [NDR];
  logic [CNT_W-1:0] count_q  [NDR];
  logic [CNT_W-1:0] count_d  [NDR];
  logic [SRC_W-1:0] rr_ptr_q [NDR];
  logic [SRC_W-1:0] rr_ptr_d [NDR];

  logic [PAYLOAD_W-1:0] pl  [NCORES];
  logic [SL_W-1:0]      tgt [NCORES];
  logic [SRC_W-1:0]     win [NDR];
  logic [NDR-1:0]       has_win, grant, push, pop, empty, byp;
  logic [NCORES-1:0]    core_grant;

  genvar gi;
  generate
    for (gi = 0; gi < NCORES; gi++) begin : g_core
      assign pl[gi]  = l2todr_req[gi*PAYLOAD_W +: PAYLOAD_W];
      assign tgt[gi] = (NDR == 1) ? '0 : pl[gi][ADDR_LSB +: SL_W];
    end
  endgenerate

  // Arbitration: scan cores starting at rr_ptr, first valid request for this slice wins.
  always_comb begin
    has_win    = '0;
    grant      = '0;
    push       = '0;
    pop        = '0;
    empty      = '0;
    byp        = '0;
    core_grant = '0;
    for (int s = 0; s < NDR; s++) win[s] = '0;
    for (int s = 0; s < NDR; s++) begin
      empty[s] = (count_q[s] == '0);
      pop[s]   = !empty[s] && !drtomem_retry[s];
      for (int k = 0; k < NCORES; k++) begin
        int idx;
        logic [SRC_W-1:0] cidx;
        idx = int'(rr_ptr_q[s]) + k;
        if (idx >= NCORES) idx = idx - NCORES;
        cidx = SRC_W'(idx);
        if (!has_win[s] && l2todr_valid[cidx] && tgt[cidx] == SL_W'(s)) begin
          has_win[s] = 1'b1;
          win[s]     = cidx;
        end
      end
      grant[s] = has_win[s] && !reset && (count_q[s] != CNT_W'(FIFO_D) || pop[s]);
`ifdef NET_REQ_BYPASS_EN
      byp[s]   = grant[s] && empty[s] && !drtomem_retry[s];
`endif
      push[s]  = grant[s] && !byp[s];
      if (grant[s]) core_grant[win[s]] = 1'b1;
    end
  end

  assign l2todr_retry = ~(l2todr_valid & core_grant);

  always_comb begin
    mem_d = mem_q;
    for (int s = 0; s < NDR; s++) begin
      wr_ptr_d[s] = wr_ptr_q[s];
      rd_ptr_d[s] = rd_ptr_q[s];
      count_d[s]  = count_q[s];
      rr_ptr_d[s] = rr_ptr_q[s];
      if (push[s]) begin
        mem_d[s][wr_ptr_q[s]] = {win[s], pl[win[s]]};
        wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(1);
      end
      if (pop[s]) rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
      case ({push[s], pop[s]})
        2'b10:   count_d[s] = count_q[s] + CNT_W'(1);
        2'b01:   count_d[s] = count_q[s] - CNT_W'(1);
        default: count_d[s] = count_q[s];
      endcase
      if (grant[s])
        rr_ptr_d[s] = (win[s] == SRC_W'(NCORES - 1)) ? '0 : win[s] + SRC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NDR; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        count_q[s]  <= '0;
        rr_ptr_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NDR; s++) begin
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        count_q[s]  <= count_d[s];
        rr_ptr_q[s] <= rr_ptr_d[s];
      end
    end
  end

  // Storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  generate
    for (gi = 0; gi < NDR; gi++) begin : g_slice
      logic [ENT_W-1:0] out_ent;
      logic             out_vld;
`ifdef NET_REQ_BYPASS_EN
      assign out_vld = !empty[gi] || grant[gi];
      assign out_ent = empty[gi] ? {win[gi], pl[win[gi]]} : mem_q[gi][rd_ptr_q[gi]];
`else
      assign out_vld = !empty[gi];
      assign out_ent = mem_q[gi][rd_ptr_q[gi]];
`endif
      assign drtomem_valid[gi]                    = out_vld;
      assign drtomem_req[gi*PAYLOAD_W +: PAYLOAD_W] = out_vld ? out_ent[PAYLOAD_W-1:0] : '0;
      assign drtomem_src[gi*SRC_W +: SRC_W]         = out_vld ? out_ent[ENT_W-1 -: SRC_W] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_net_ncore_ndr_req.sv
// Directed bench for net_ncore_ndr_req with default parameters (2 cores, 2 slices, FIFO depth 2).
module tb_net_ncore_ndr_req;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   l2todr_valid;
  logic [1:0]   l2todr_retry;
  logic [127:0] l2todr_req;
  logic [1:0]   drtomem_valid;
  logic [1:0]   drtomem_retry;
  logic [127:0] drtomem_req;
  logic [1:0]   drtomem_src;

  int n_assert = 0;
  int n_fail   = 0;

  net_ncore_ndr_req dut (
    .clk           (clk),
    .reset         (reset),
    .l2todr_valid  (l2todr_valid),
    .l2todr_retry  (l2todr_retry),
    .l2todr_req    (l2todr_req),
    .drtomem_valid (drtomem_valid),
    .drtomem_retry (drtomem_retry),
    .drtomem_req   (drtomem_req),
    .drtomem_src   (drtomem_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic [63:0] r0, r1;
    logic [1:0]  dr;
    logic [1:0]  exp_retry;
    logic [1:0]  exp_dv;
    logic        exp_src0, exp_src1;
    logic [63:0] exp_req0, exp_req1;
  } vec_t;

  vec_t tbl[$];

  // Payload with a unique tag in the upper bits and the slice select at bit 6.
  function automatic logic [63:0] mkp(input int n, input int s);
    return (64'(n) << 16) | (64'(s) << 6);
  endfunction

  task automatic add(input logic [1:0] v, input int a0, input int s0, input int a1, input int s1,
                     input logic [1:0] dr, input logic [1:0] er, input logic [1:0] edv,
                     input logic es0, input int eq0, input logic es1, input int eq1);
    vec_t e;
    e.v = v; e.r0 = mkp(a0, s0); e.r1 = mkp(a1, s1); e.dr = dr;
    e.exp_retry = er; e.exp_dv = edv;
    e.exp_src0 = es0; e.exp_src1 = es1;
    e.exp_req0 = mkp(eq0, 0); e.exp_req1 = mkp(eq1, 1);
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] r0, input logic [63:0] r1,
                       input logic [1:0] dr);
    l2todr_valid  = v;
    l2todr_req    = {r1, r0};
    drtomem_retry = dr;
  endtask

  initial begin
    reset = 1'b1;
    drive(2'b11, mkp(99, 0), mkp(98, 1), 2'b00);

    // T1: single request to slice 1
    add(2'b01, 1,1, 0,0, 2'b00, 2'b10, 2'b00, 0,0,  0,0);
    add(2'b00, 0,0, 0,0, 2'b00, 2'b11, 2'b10, 0,0,  0,1);
    add(2'b00, 0,0, 0,0, 2'b00, 2'b11, 2'b00, 0,0,  0,0);
    // T2: both cores on slice 0, grants alternate
    add(2'b11, 10,0, 20,0, 2'b00, 2'b10, 2'b00, 0,0,  0,0);
    add(2'b11, 11,0, 20,0, 2'b00, 2'b01, 2'b01, 0,10, 0,0);
    add(2'b11, 11,0, 21,0, 2'b00, 2'b10, 2'b01, 1,20, 0,0);
    add(2'b11, 12,0, 21,0, 2'b00, 2'b01, 2'b01, 0,11, 0,0);
    add(2'b11, 12,0, 22,0, 2'b00, 2'b10, 2'b01, 1,21, 0,0);
    add(2'b11, 13,0, 22,0, 2'b00, 2'b01, 2'b01, 0,12, 0,0);
    add(2'b11, 13,0, 23,0, 2'b00, 2'b10, 2'b01, 1,22, 0,0);
    add(2'b10, 0,0,  23,0, 2'b00, 2'b01, 2'b01, 0,13, 0,0);
    add(2'b00, 0,0,  0,0,  2'b00, 2'b11, 2'b01, 1,23, 0,0);
    add(2'b00, 0,0,  0,0,  2'b00, 2'b11, 2'b00, 0,0,  0,0);
    // T3/T4: slice 0 backpressured for 5 cycles, then full FIFO with pop+push
    add(2'b01, 30,0, 0,0, 2'b01, 2'b10, 2'b00, 0,0,  0,0);
    add(2'b01, 31,0, 0,0, 2'b01, 2'b10, 2'b01, 0,30, 0,0);
    add(2'b01, 32,0, 0,0, 2'b01, 2'b11, 2'b01, 0,30, 0,0);
    add(2'b01, 32,0, 0,0, 2'b01, 2'b11, 2'b01, 0,30, 0,0);
    add(2'b01, 32,0, 0,0, 2'b01, 2'b11, 2'b01, 0,30, 0,0);
    add(2'b01, 32,0, 0,0, 2'b00, 2'b10, 2'b01, 0,30, 0,0);
    add(2'b01, 33,0, 0,0, 2'b00, 2'b10, 2'b01, 0,31, 0,0);
    add(2'b00, 0,0,  0,0, 2'b00, 2'b11, 2'b01, 0,32, 0,0);
    add(2'b00, 0,0,  0,0, 2'b00, 2'b11, 2'b01, 0,33, 0,0);
    add(2'b00, 0,0,  0,0, 2'b00, 2'b11, 2'b00, 0,0,  0,0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_retry", 64'(l2todr_retry), 64'(2'b11));
    chk("rst_dv", 64'(drtomem_valid), 64'(2'b00));
    chk("rst_req", drtomem_req[63:0] | drtomem_req[127:64], 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(2'b00, 64'd0, 64'd0, 2'b00);

`ifndef NET_REQ_BYPASS_EN
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].r0, tbl[i].r1, tbl[i].dr);
      #1;
      chk($sformatf("v%0d_retry", i), 64'(l2todr_retry), 64'(tbl[i].exp_retry));
      chk($sformatf("v%0d_dv", i), 64'(drtomem_valid), 64'(tbl[i].exp_dv));
      if (tbl[i].exp_dv[0]) begin
        chk($sformatf("v%0d_src0", i), 64'(drtomem_src[0]), 64'(tbl[i].exp_src0));
        chk($sformatf("v%0d_req0", i), drtomem_req[63:0], tbl[i].exp_req0);
      end
      if (tbl[i].exp_dv[1]) begin
        chk($sformatf("v%0d_src1", i), 64'(drtomem_src[1]), 64'(tbl[i].exp_src1));
        chk($sformatf("v%0d_req1", i), drtomem_req[127:64], tbl[i].exp_req1);
      end
      $display("vec %0d: valid=%b retry=%b dv=%b", i, tbl[i].v, l2todr_retry, drtomem_valid);
    end

    // T5: two entries buffered in slice 1 (rr_ptr[1] is 1 here), then async reset
    @(negedge clk); drive(2'b01, mkp(40, 1), 64'd0, 2'b10); #1;
    chk("t5_fill0", 64'(l2todr_retry), 64'(2'b10));
    @(negedge clk); drive(2'b01, mkp(41, 1), 64'd0, 2'b10); #1;
    chk("t5_fill1", 64'(l2todr_retry), 64'(2'b10));
    @(negedge clk); drive(2'b00, 64'd0, 64'd0, 2'b10); #1;
    chk("t5_full_dv", 64'(drtomem_valid), 64'(2'b10));
    chk("t5_head", drtomem_req[127:64], mkp(40, 1));
    drive(2'b01, mkp(42, 1), 64'd0, 2'b10);
    #1 reset = 1'b1;
    #1;
    chk("t5_async_dv", 64'(drtomem_valid), 64'(2'b00));
    chk("t5_async_req", drtomem_req[127:64], 64'd0);
    chk("t5_async_retry", 64'(l2todr_retry), 64'(2'b11));
    $display("t5 reset asserted: dv=%b retry=%b", drtomem_valid, l2todr_retry);
    @(negedge clk);
    reset = 1'b0;
    drive(2'b11, mkp(50, 1), mkp(60, 1), 2'b00); #1;
    chk("t5_rr_reset", 64'(l2todr_retry), 64'(2'b10));
    chk("t5_idle", 64'(drtomem_valid), 64'(2'b00));
    @(negedge clk); drive(2'b00, 64'd0, 64'd0, 2'b00); #1;
    chk("t5_first_dv", 64'(drtomem_valid), 64'(2'b10));
    chk("t5_first_src", 64'(drtomem_src[1]), 64'd0);
    chk("t5_first_req", drtomem_req[127:64], mkp(50, 1));
    $display("t5 post-reset: src=%b req=%h", drtomem_src[1], drtomem_req[127:64]);
    @(negedge clk); #1;
    chk("t5_drained", 64'(drtomem_valid), 64'(2'b00));
`else
    // T6: bypass on an empty FIFO, then bypass blocked by retry falls back to a push
    @(negedge clk); drive(2'b10, 64'd0, mkp(70, 0), 2'b00); #1;
    chk("t6_dv", 64'(drtomem_valid), 64'(2'b01));
    chk("t6_src", 64'(drtomem_src[0]), 64'd1);
    chk("t6_req", drtomem_req[63:0], mkp(70, 0));
    chk("t6_retry", 64'(l2todr_retry), 64'(2'b01));
    $display("t6 bypass: dv=%b src=%b", drtomem_valid, drtomem_src);
    @(negedge clk); drive(2'b00, 64'd0, 64'd0, 2'b00); #1;
    chk("t6_no_push", 64'(drtomem_valid), 64'(2'b00));
    @(negedge clk); drive(2'b10, 64'd0, mkp(71, 0), 2'b01); #1;
    chk("t6b_dv", 64'(drtomem_valid), 64'(2'b01));
    chk("t6b_req", drtomem_req[63:0], mkp(71, 0));
    chk("t6b_retry", 64'(l2todr_retry), 64'(2'b01));
    @(negedge clk); drive(2'b00, 64'd0, 64'd0, 2'b00); #1;
    chk("t6b_fifo_dv", 64'(drtomem_valid), 64'(2'b01));
    chk("t6b_fifo_src", 64'(drtomem_src[0]), 64'd1);
    chk("t6b_fifo_req", drtomem_req[63:0], mkp(71, 0));
    $display("t6 pushed: dv=%b req=%h", drtomem_valid, drtomem_req[63:0]);
    @(negedge clk); #1;
    chk("t6b_drained", 64'(drtomem_valid), 64'(2'b00));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
